pmsm_commutation_ctrl: RTL and testbench
========================================

// Module: pmsm_commutation_ctrl
// PURPOSE
//  Sequences phase-drive vectors for the PMSM_v4 motor model.
//  Owns the PWM carrier and a start-up state machine: align rotor, open-loop ramp
//  through the six sectors, then closed-loop commutation from rotor position.
//  Drives PMSM_v4.V_phase in place of the free-running sector generator used in simulation.
// PARAMETERS
//  PWM_PERIOD    2000  carrier length in clk cycles; counter runs 0..PWM_PERIOD-1
//  ALIGN_PERIODS 64    carrier periods held in sector 1 during ALIGN
//  RAMP_START    32    initial carrier periods per sector in RAMP
//  RAMP_MIN      4     final periods per sector; RUN entered when reached
//  DEAD_CYCLES   8     turn-on delay per phase (used only with PMSM_DEADTIME_EN)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  enable      in   1   start/run request; level sensitive
//  dir         in   1   0: sectors 1->2->..6->1; 1: 1->6->5..->1 (RAMP only)
//  duty        in   16  on-time in clk cycles per carrier period
//  position    in   16  rotor electrical angle, 0..65535 = 0..360 deg
//  fault       in   1   overcurrent/overvoltage trip, level sensitive
//  V_phase     out  3   {a,b,c} phase drive, registered
//  sector      out  3   active sector 1..6; 0 when not driving
//  state       out  3   IDLE=0 ALIGN=1 RAMP=2 RUN=3 FAULT=4
//  period_tick out  1   one-cycle pulse, last cycle of each carrier period
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, carrier cnt=0, state IDLE, ramp_len=RAMP_START.
//  Carrier: cnt increments every clk, wraps PWM_PERIOD-1 -> 0; period_tick = (cnt==PWM_PERIOD-1).
//    Carrier runs in every state.
//  Vector table: S1=100 S2=110 S3=010 S4=011 S5=001 S6=101; sector 0 -> 000.
//  V_phase(next) = table[sector] & {3{cnt < duty_c}}, duty_c = min(duty, PWM_PERIOD).
//    One-cycle latency from cnt; duty=0 -> always 000, duty>=PWM_PERIOD -> 100% on.
//  Sector/state changes take effect only on period_tick edges.
//    Exceptions: fault and enable=0 act on the next clk edge.
//  IDLE: sector=0. enable & !fault & period_tick -> ALIGN, sector=1, period count=0.
//  ALIGN: hold sector 1 for ALIGN_PERIODS periods, then -> RAMP, ramp_len=RAMP_START.
//  RAMP: after ramp_len periods in a sector, step sector per dir (6->1 / 1->6 wrap).
//    On each step, ramp_len decrements by 1 if > RAMP_MIN.
//    The step that makes ramp_len==RAMP_MIN also moves state -> RUN.
//  RUN: at each period_tick, sector = 1 + min(position/10923, 5).
//    Integer compare against constants; no divider.
//  enable=0 in ALIGN/RAMP/RUN: next edge -> IDLE, V_phase=000, sector=0, counters cleared.
//  fault=1 in any state: next edge -> FAULT, V_phase=000, sector=0; fault has priority over enable.
//  FAULT exit: only when fault=0 && enable=0 -> IDLE. enable held high keeps FAULT latched.
//  Inputs duty/position/dir: sampled on use, no extra synchronisation.
// CONFIGURATION
//  PMSM_DEADTIME_EN defined:
//    A phase 0->1 transition of V_phase is delayed DEAD_CYCLES clks.
//    Per-phase counter; 1->0 transitions are immediate.
//    An on-window shorter than DEAD_CYCLES produces no pulse.
//  PMSM_DEADTIME_EN undefined: no delay logic; DEAD_CYCLES ignored.
// STRUCTURE
//  Package pmsm_ctrl_pkg:
//    state encoding constants, 6-entry vector table function.
//    Sector boundary constants (10923, 21846, 32769, 43692, 54615).
//  Sub-module pwm_carrier: cnt + period_tick, parameter PWM_PERIOD.
//  FSM, ramp timer and output stage stay in this module.
// TESTING (PWM_PERIOD=20 ALIGN_PERIODS=3 RAMP_START=4 RAMP_MIN=2 DEAD_CYCLES=2)
//  1. Reset: rst_n=0 mid-RUN
//       -> same time V_phase=000, sector=0, state=0, period_tick=0; cnt restarts at 0 after release.
//  2. Align: enable=1, duty=10
//       -> state=1, sector=1 at first tick.
//       -> V_phase=100 for 10 clks, 000 for 10 clks (1-clk lag).
//       -> 3 periods, then state=2.
//  3. Ramp, dir=0:
//       -> sector 1->2 after 4 periods (ramp_len 4->3).
//       -> 2->3 after 3 periods (3->2, state=3).
//     Repeat with dir=1: 1->6->5.
//  4. RUN:
//       position=30000 -> sector=3, V_phase pattern 010 at next tick.
//       position=65535 -> sector=6 (101).
//       position=0 -> sector=1.
//  5. Fault: fault=1 mid-RUN -> next edge V_phase=000, state=4.
//       fault=0 with enable=1 -> stays 4.
//       enable=0 -> state=0.
//  6. Duty edges: duty=0 -> V_phase always 000; duty=25 -> continuous pattern.
//     With PMSM_DEADTIME_EN: rising edges lag 2 clks, duty=1 -> no pulse.

Source files
------------

// File: rtl/pmsm_ctrl_pkg.sv
// Shared types and helpers for the PMSM commutation controller:
// state encoding, sector boundaries, phase vector table and sector stepping.
package pmsm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Rotor angle thresholds splitting 0..65535 into six 60-degree sectors
    localparam logic [15:0] SEC_B1 = 16'd10923;
    localparam logic [15:0] SEC_B2 = 16'd21846;
    localparam logic [15:0] SEC_B3 = 16'd32769;
    localparam logic [15:0] SEC_B4 = 16'd43692;
    localparam logic [15:0] SEC_B5 = 16'd54615;

    // {a,b,c} drive pattern per sector; sector 0 means not driving
    function automatic logic [2:0] vec_of(input logic [2:0] s);
        case (s)
            3'd1:    return 3'b100;
            3'd2:    return 3'b110;
            3'd3:    return 3'b010;
            3'd4:    return 3'b011;
            3'd5:    return 3'b001;
            3'd6:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] sector_of(input logic [15:0] pos);
        if (pos < SEC_B1) return 3'd1;
        if (pos < SEC_B2) return 3'd2;
        if (pos < SEC_B3) return 3'd3;
        if (pos < SEC_B4) return 3'd4;
        if (pos < SEC_B5) return 3'd5;
        return 3'd6;
    endfunction

    function automatic logic [2:0] sector_step(input logic [2:0] s, input logic rev);
        if (rev) return (s == 3'd1) ? 3'd6 : s - 3'd1;
        return (s == 3'd6) ? 3'd1 : s + 3'd1;
    endfunction

endpackage

// File: rtl/pmsm_commutation_ctrl_if.sv
// Control/status bundle between the commutation controller and its host.
interface pmsm_commutation_ctrl_if;
    logic        enable;
    logic        dir;
    logic        fault;
    logic [15:0] duty;
    logic [15:0] position;
    logic [2:0]  V_phase;
    logic [2:0]  sector;
    logic [2:0]  state;
    logic        period_tick;

    modport master (
        output enable, dir, duty, position, fault,
        input  V_phase, sector, state, period_tick
    );

    modport slave (
        input  enable, dir, duty, position, fault,
        output V_phase, sector, state, period_tick
    );
endinterface

// File: rtl/pwm_carrier.sv
// PWM carrier: free-running 0..PWM_PERIOD-1 counter with a registered end-of-period pulse.
module pwm_carrier #(
    parameter int unsigned PWM_PERIOD = 2000,
    parameter int unsigned CW         = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] cnt,
    output logic          period_tick
);

    // Tick is decoded one count early so it aligns with cnt == PWM_PERIOD-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            cnt         <= (cnt == CW'(PWM_PERIOD - 1)) ? '0 : cnt + CW'(1);
            period_tick <= (cnt == CW'(PWM_PERIOD - 2));
        end
    end

endmodule

// File: rtl/pmsm_commutation_ctrl.sv
// PMSM start-up and commutation sequencer: align, open-loop ramp, closed-loop run.
// Optional turn-on dead time per phase when PMSM_DEADTIME_EN is defined.
module pmsm_commutation_ctrl
    import pmsm_ctrl_pkg::*;
#(
    parameter int unsigned PWM_PERIOD    = 2000,
    parameter int unsigned ALIGN_PERIODS = 64,
    parameter int unsigned RAMP_START    = 32,
    parameter int unsigned RAMP_MIN      = 4,
    parameter int unsigned DEAD_CYCLES   = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    pmsm_commutation_ctrl_if.slave bus
);

    localparam int unsigned CW   = $clog2(PWM_PERIOD);
    localparam int unsigned PMAX = (ALIGN_PERIODS > RAMP_START) ? ALIGN_PERIODS : RAMP_START;
    localparam int unsigned PCW  = $clog2(PMAX + 1);

    if (PWM_PERIOD < 2 || PWM_PERIOD > 65536 || RAMP_MIN == 0 || RAMP_MIN > RAMP_START ||
        ALIGN_PERIODS == 0 || DEAD_CYCLES >= PWM_PERIOD) begin : g_bad_cfg
        $error("pmsm_commutation_ctrl: unsupported parameter set");
    end

    logic [CW-1:0]  cnt;
    logic           tick;
    state_e         state_q, state_d;
    logic [2:0]     sector_q, sector_d;
    logic [PCW-1:0] pcnt_q, pcnt_d, pcnt_inc;
    logic [PCW-1:0] rlen_q, rlen_d;
    logic [2:0]     drive_d;
    logic [2:0]     vphase_q;

    pwm_carrier #(
        .PWM_PERIOD (PWM_PERIOD),
        .CW         (CW)
    ) u_carrier (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt         (cnt),
        .period_tick (tick)
    );

    // Next-state: fault and enable loss act immediately, all else waits for a tick
    always_comb begin
        state_d  = state_q;
        sector_d = sector_q;
        pcnt_d   = pcnt_q;
        rlen_d   = rlen_q;
        pcnt_inc = pcnt_q + PCW'(1);
        drive_d  = 3'b000;

        if (bus.fault) begin
            state_d  = ST_FAULT;
            sector_d = 3'd0;
            pcnt_d   = '0;
            rlen_d   = PCW'(RAMP_START);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable && tick) begin
                        state_d  = ST_ALIGN;
                        sector_d = 3'd1;
                        pcnt_d   = '0;
                    end
                end
                ST_FAULT: begin
                    if (!bus.enable) state_d = ST_IDLE;
                end
                default: begin
                    if (!bus.enable) begin
                        state_d  = ST_IDLE;
                        sector_d = 3'd0;
                        pcnt_d   = '0;
                        rlen_d   = PCW'(RAMP_START);
                    end else if (tick) begin
                        case (state_q)
                            ST_ALIGN: begin
                                if (pcnt_inc == PCW'(ALIGN_PERIODS)) begin
                                    state_d = ST_RAMP;
                                    pcnt_d  = '0;
                                    rlen_d  = PCW'(RAMP_START);
                                end else begin
                                    pcnt_d = pcnt_inc;
                                end
                            end
                            ST_RAMP: begin
                                if (pcnt_inc == rlen_q) begin
                                    pcnt_d   = '0;
                                    sector_d = sector_step(sector_q, bus.dir);
                                    if (rlen_q > PCW'(RAMP_MIN)) begin
                                        rlen_d = rlen_q - PCW'(1);
                                        if (rlen_q - PCW'(1) == PCW'(RAMP_MIN)) state_d = ST_RUN;
                                    end
                                end else begin
                                    pcnt_d = pcnt_inc;
                                end
                            end
                            ST_RUN:  sector_d = sector_of(bus.position);
                            default: ;
                        endcase
                    end
                end
            endcase
        end

        // cnt < PWM_PERIOD always, so comparing against raw duty equals the clamped duty
        if (!bus.fault && bus.enable && (16'(cnt) < bus.duty)) drive_d = vec_of(sector_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sector_q <= 3'd0;
            pcnt_q   <= '0;
            rlen_q   <= PCW'(RAMP_START);
        end else begin
            state_q  <= state_d;
            sector_q <= sector_d;
            pcnt_q   <= pcnt_d;
            rlen_q   <= rlen_d;
        end
    end

`ifdef PMSM_DEADTIME_EN
    localparam int unsigned DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    logic [DW-1:0] dead_q [3];

    // A phase turns on only after its drive has been requested for DEAD_CYCLES clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vphase_q <= 3'b000;
            for (int i = 0; i < 3; i++) dead_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!drive_d[i]) begin
                    dead_q[i]   <= '0;
                    vphase_q[i] <= 1'b0;
                end else if (dead_q[i] == DW'(DEAD_CYCLES)) begin
                    vphase_q[i] <= 1'b1;
                end else begin
                    dead_q[i]   <= dead_q[i] + DW'(1);
                    vphase_q[i] <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vphase_q <= 3'b000;
        else        vphase_q <= drive_d;
    end
`endif

    assign bus.V_phase     = vphase_q;
    assign bus.sector      = sector_q;
    assign bus.state       = state_q;
    assign bus.period_tick = tick;

endmodule

// File: tb/tb_pmsm_commutation_ctrl.sv
// Bench for pmsm_commutation_ctrl: directed start-up sequence with literal checks,
// then randomized stimulus checked every cycle against a behavioural model.
module tb_pmsm_commutation_ctrl;

    localparam int P  = 20;
    localparam int A  = 3;
    localparam int RS = 4;
    localparam int RM = 2;
    localparam int D  = 2;
`ifdef PMSM_DEADTIME_EN
    localparam int LAG = D;
`else
    localparam int LAG = 0;
`endif

    logic clk;
    logic rst_n;
    pmsm_commutation_ctrl_if bus ();

    pmsm_commutation_ctrl #(
        .PWM_PERIOD    (P),
        .ALIGN_PERIODS (A),
        .RAMP_START    (RS),
        .RAMP_MIN      (RM),
        .DEAD_CYCLES   (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int tnow = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int vtab(input int s);
        case (s)
            1: return 4;
            2: return 6;
            3: return 2;
            4: return 3;
            5: return 1;
            6: return 5;
            default: return 0;
        endcase
    endfunction

    // Behavioural model: carrier position, start-up phase, periods in phase, ramp length
    int m_cnt = 0, m_state = 0, m_sector = 0, m_pc = 0, m_rlen = RS, m_v = 0, m_tick = 0;
    int m_run[3] = '{0, 0, 0};
    int mt, mdc, mraw, msec;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt = 0; m_state = 0; m_sector = 0; m_pc = 0; m_rlen = RS; m_v = 0; m_tick = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
        end else begin
            mt   = (m_cnt == P - 1) ? 1 : 0;
            mdc  = (int'(bus.duty) > P) ? P : int'(bus.duty);
            mraw = (bus.fault || !bus.enable || m_cnt >= mdc) ? 0 : vtab(m_sector);
            if (bus.fault) begin
                m_state = 4; m_sector = 0; m_pc = 0; m_rlen = RS;
            end else if (m_state == 0) begin
                if (bus.enable && mt == 1) begin m_state = 1; m_sector = 1; m_pc = 0; end
            end else if (m_state == 4) begin
                if (!bus.enable) m_state = 0;
            end else if (!bus.enable) begin
                m_state = 0; m_sector = 0; m_pc = 0; m_rlen = RS;
            end else if (mt == 1) begin
                if (m_state == 1) begin
                    m_pc++;
                    if (m_pc == A) begin m_state = 2; m_pc = 0; m_rlen = RS; end
                end else if (m_state == 2) begin
                    m_pc++;
                    if (m_pc == m_rlen) begin
                        m_pc = 0;
                        m_sector = bus.dir ? ((m_sector == 1) ? 6 : m_sector - 1) : (m_sector % 6) + 1;
                        if (m_rlen > RM) begin
                            m_rlen--;
                            if (m_rlen == RM) m_state = 3;
                        end
                    end
                end else begin
                    msec = int'(bus.position) / 10923;
                    m_sector = 1 + ((msec > 5) ? 5 : msec);
                end
            end
`ifdef PMSM_DEADTIME_EN
            m_v = 0;
            for (int i = 0; i < 3; i++) begin
                m_run[i] = ((mraw >> i) & 1) ? m_run[i] + 1 : 0;
                if (m_run[i] > D) m_v = m_v | (1 << i);
            end
`else
            m_v = mraw;
`endif
            m_cnt  = (m_cnt + 1) % P;
            m_tick = (m_cnt == P - 1) ? 1 : 0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    initial forever begin
        @(negedge clk);
        if (rst_n && chk_en) begin
            check("v_phase", 32'(bus.V_phase), 32'(m_v));
            check("sector", 32'(bus.sector), 32'(m_sector));
            check("state", 32'(bus.state), 32'(m_state));
            check("period_tick", 32'(bus.period_tick), 32'(m_tick));
        end
    end

    task automatic adv(input int target);
        while (tnow < target) begin
            @(negedge clk);
            tnow++;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] edge_pos(input int k);
        case (k)
            0: return 16'd10922;  1: return 16'd10923;  2: return 16'd21845;
            3: return 16'd21846;  4: return 16'd32768;  5: return 16'd32769;
            6: return 16'd43691;  7: return 16'd43692;  8: return 16'd54614;
            9: return 16'd54615;  10: return 16'd65535; default: return 16'd0;
        endcase
    endfunction

    int seq[$];
    int last, n, nz, fault_left, off_left;

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.dir = 1'b0; bus.fault = 1'b0;
        bus.duty = 16'd10; bus.position = 16'd0;
        #23;
        check("reset_v_phase", 32'(bus.V_phase), 0);
        check("reset_sector", 32'(bus.sector), 0);
        check("reset_state", 32'(bus.state), 0);
        check("reset_tick", 32'(bus.period_tick), 0);

        bus.enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        adv(19);        check("tick_first", 32'(bus.period_tick), 1);
        adv(20);        check("align_state", 32'(bus.state), 1);
                        check("align_sector", 32'(bus.sector), 1);
                        check("align_v_lag", 32'(bus.V_phase), 0);
        adv(21 + LAG);  check("align_v_on", 32'(bus.V_phase), 4);
        adv(30);        check("align_v_last_on", 32'(bus.V_phase), 4);
        adv(31);        check("align_v_off", 32'(bus.V_phase), 0);
        adv(79);        check("align_hold", 32'(bus.state), 1);
        adv(80);        check("ramp_entry", 32'(bus.state), 2);
        adv(159);       check("ramp_s1_hold", 32'(bus.sector), 1);
        adv(160);       check("ramp_s2", 32'(bus.sector), 2);
        adv(219);       check("ramp_s2_hold", 32'(bus.sector), 2);
        adv(220);       check("ramp_s3", 32'(bus.sector), 3);
                        check("run_entry", 32'(bus.state), 3);
        bus.position = 16'd65535;
        adv(240);       check("run_pos_max", 32'(bus.sector), 6);
        adv(241 + LAG); check("run_v_101", 32'(bus.V_phase), 5);
        bus.position = 16'd0;
        adv(260);       check("run_pos_zero", 32'(bus.sector), 1);
        bus.position = 16'd30000;
        adv(280);       check("run_pos_30000", 32'(bus.sector), 3);
        adv(281 + LAG); check("run_v_010", 32'(bus.V_phase), 2);

        adv(285);
        bus.fault = 1'b1;
        adv(286);       check("fault_state", 32'(bus.state), 4);
                        check("fault_v", 32'(bus.V_phase), 0);
                        check("fault_sector", 32'(bus.sector), 0);
        bus.fault = 1'b0;
        cyc(25);        check("fault_latched", 32'(bus.state), 4);
        bus.enable = 1'b0;
        cyc(1);         check("fault_exit", 32'(bus.state), 0);

        // Reverse ramp: expect sectors 1 -> 6 -> 5 then RUN
        bus.enable = 1'b1; bus.dir = 1'b1;
        last = 0; n = 0;
        while (32'(bus.state) != 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.sector != 0 && int'(bus.sector) != last) begin
                last = int'(bus.sector);
                seq.push_back(last);
            end
        end
        check("dir1_reach_run", 32'(n < 400), 1);
        check("dir1_steps", 32'(seq.size()), 3);
        if (seq.size() == 3) begin
            check("dir1_seq0", 32'(seq[0]), 1);
            check("dir1_seq1", 32'(seq[1]), 6);
            check("dir1_seq2", 32'(seq[2]), 5);
        end

        bus.position = 16'd40000;
        bus.duty = 16'd0;
        cyc(20);
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.V_phase != 3'b000) nz++;
        end
        check("duty0_never_on", 32'(nz), 0);
        bus.duty = 16'd25;
        cyc(21);
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.V_phase != 3'b011) nz++;
        end
        check("duty25_continuous", 32'(nz), 0);
`ifdef PMSM_DEADTIME_EN
        bus.duty = 16'd1;
        cyc(20);
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.V_phase != 3'b000) nz++;
        end
        check("dead_short_pulse", 32'(nz), 0);
`endif

        // Randomized phase: occasional faults and enable drops, boundary positions
        fault_left = 0; off_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (fault_left > 0) begin
                bus.fault = 1'b1;
                fault_left--;
                if (fault_left == 0) off_left = $urandom_range(0, 20);
            end else begin
                bus.fault = 1'b0;
                if ($urandom_range(0, 599) == 0) fault_left = $urandom_range(1, 8);
            end
            if (off_left > 0) begin
                bus.enable = 1'b0;
                off_left--;
            end else begin
                bus.enable = 1'b1;
                if ($urandom_range(0, 499) == 0) off_left = $urandom_range(1, 40);
            end
            if ($urandom_range(0, 49) == 0) bus.duty = 16'($urandom_range(0, 25));
            if ($urandom_range(0, 199) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 3) == 0) bus.position = edge_pos($urandom_range(0, 11));
            else                           bus.position = 16'($urandom_range(0, 65535));
            cyc(1);
        end

        // Asynchronous reset in the middle of RUN
        bus.fault = 1'b0; bus.enable = 1'b0; bus.duty = 16'd10;
        cyc(2);
        bus.enable = 1'b1;
        n = 0;
        while (32'(bus.state) != 3 && n < 600) begin
            cyc(1);
            n++;
        end
        check("reach_run_before_reset", 32'(n < 600), 1);
        cyc(5);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_v", 32'(bus.V_phase), 0);
        check("async_rst_sector", 32'(bus.sector), 0);
        check("async_rst_state", 32'(bus.state), 0);
        check("async_rst_tick", 32'(bus.period_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(18);  check("post_rst_no_tick", 32'(bus.period_tick), 0);
        cyc(1);   check("post_rst_tick", 32'(bus.period_tick), 1);
                  check("post_rst_idle", 32'(bus.state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
